// File: rtl/output_argmax.sv
// Frame-wise argmax over num_classes signed neuron scores, with a valid/ready result port.
// Defining OUTPUT_ARGMAX_MARGIN_EN adds a 'margin' output (winner minus runner-up).
module output_argmax #(
  parameter int num_classes = 10,
  parameter int resolution  = 8,
  parameter int index_width = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [resolution-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [index_width-1:0] digit,
  output logic signed [resolution-1:0] max_score
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  ,
  output logic        [resolution:0]   margin
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid/data are held by the source until that edge.
  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic        [index_width-1:0] cnt_q;
  logic        [index_width-1:0] idx_q, idx_d;
  logic signed [resolution-1:0]  best_q, best_d;

  logic accept;
  logic last;
  logic release_res;
  logic first;
  logic greater;

  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign first       = (cnt_q == '0);
  assign last        = (cnt_q == index_width'(num_classes - 1));
  assign greater     = (in_data > best_q);

  assign digit     = idx_q;
  assign max_score = best_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last) state_d = DONE;
      DONE:    if (release_res)    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Strict '>' keeps the lower index on ties.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (accept && (first || greater)) begin
      best_d = in_data;
      idx_d  = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      if (release_res)
        cnt_q <= '0;
      else if (accept && !last)
        cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef OUTPUT_ARGMAX_MARGIN_EN
  // Runner-up tracking: a score equal to the leader becomes the runner-up,
  // so a tie for first place yields margin 0.
  logic signed [resolution-1:0] sec_q, sec_d;
  logic                         sec_vld_q, sec_vld_d;
  logic        [resolution:0]   margin_q;
  logic signed [resolution:0]   diff;

  always_comb begin
    sec_d     = sec_q;
    sec_vld_d = sec_vld_q;
    if (accept) begin
      if (first) begin
        sec_vld_d = 1'b0;
      end else if (greater) begin
        sec_d     = best_q;
        sec_vld_d = 1'b1;
      end else if (!sec_vld_q || (in_data > sec_q)) begin
        sec_d     = in_data;
        sec_vld_d = 1'b1;
      end
    end
  end

  assign diff   = {best_d[resolution-1], best_d} - {sec_d[resolution-1], sec_d};
  assign margin = margin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q     <= '0;
      sec_vld_q <= 1'b0;
      margin_q  <= '0;
    end else begin
      sec_q     <= sec_d;
      sec_vld_q <= sec_vld_d;
      if (accept && last)
        margin_q <= diff;
    end
  end
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax; margin checks compile in with OUTPUT_ARGMAX_MARGIN_EN.
module tb_output_argmax;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic        [3:0] digit;
  logic signed [7:0] max_score;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic        [8:0] margin;
`endif

  int checks;
  int failures;
  int f[10];

  output_argmax #(
    .num_classes(10),
    .resolution (8),
    .index_width(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .digit    (digit),
    .max_score(max_score)
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    ,
    .margin   (margin)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // driver: returns just after the accepting edge
  task automatic send_score(input int s);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(s);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int s[10], input bit gap);
    for (int i = 0; i < 10; i++) begin
      send_score(s[i]);
      if (gap && i != 9) @(posedge clk);
    end
  endtask

  // samples on the falling edge right after the final accept
  task automatic check_result(input string tag, input int e_digit, input int e_max, input int e_margin);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_digit"}, 32'(digit), 32'(e_digit));
    check({tag, "_max_score"}, 32'($signed(max_score)), 32'(e_max));
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    check({tag, "_margin"}, 32'(margin), 32'(e_margin));
`else
    if (e_margin < 0) check({tag, "_margin_arg"}, 32'(e_margin), 32'd0);
`endif
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_max_score", 32'($signed(max_score)), 32'd0);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    check("rst_margin", 32'(margin), 32'd0);
`endif

    // basic frame with out_ready held high: one cycle in DONE, then back to COLLECT
    f = '{3, -7, 12, 5, 0, 1, 2, -1, 4, 9};
    out_ready = 1'b1;
    send_frame(f, 1'b0);
    check_result("basic", 2, 12, 3);
    @(negedge clk);
    check("basic_auto_rel_out_valid", 32'(out_valid), 32'd0);
    check("basic_auto_rel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // tie for first keeps the lower index
    f = '{20, 5, 20, 1, 2, 3, 4, -5, 6, 7};
    send_frame(f, 1'b0);
    check_result("tie", 0, 20, 0);
    consume("tie");

    // all negative
    f = '{-128, -50, -3, -90, -10, -20, -4, -100, -60, -5};
    send_frame(f, 1'b0);
    check_result("neg", 2, -3, 1);
    consume("neg");

    // every score at the minimum
    f = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    send_frame(f, 1'b0);
    check_result("allmin", 0, -128, 0);
    consume("allmin");

    // winner is the last score; widest possible margin
    f = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 127};
    send_frame(f, 1'b0);
    check_result("lastwin", 9, 127, 128);
    consume("lastwin");

    // backpressure: hold result 5 cycles while upstream keeps pulsing
    f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(f, 1'b0);
    check_result("bp", 9, 10, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_data  = 8'sd127;
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_digit", 32'(digit), 32'd9);
      check("bp_hold_max", 32'($signed(max_score)), 32'd10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("bp");

    // next frame starts at class 0: max sits at index 0
    f = '{60, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(f, 1'b0);
    check_result("after_bp", 0, 60, 51);
    consume("after_bp");

    // in_valid every other cycle gives the same result as back-to-back
    f = '{3, -7, 12, 5, 0, 1, 2, -1, 4, 9};
    send_frame(f, 1'b1);
    check_result("gap", 2, 12, 3);
    consume("gap");

    // reset mid-frame discards the partial scores
    for (int i = 0; i < 6; i++) send_score(100);
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_digit", 32'(digit), 32'd0);
    check("midrst_max", 32'($signed(max_score)), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_idle_out_valid", 32'(out_valid), 32'd0);
    end
    f = '{-128, -50, -3, -90, -10, -20, -4, -100, -60, -5};
    send_frame(f, 1'b0);
    check_result("postrst", 2, -3, 1);

    // reset while a result is pending
    do_reset();
    @(negedge clk);
    check("donerst_out_valid", 32'(out_valid), 32'd0);
    check("donerst_in_ready", 32'(in_ready), 32'd1);
    check("donerst_max", 32'($signed(max_score)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
